// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-port memory between instruction fetch and data access.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating grants under contention (default: data priority).
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_data_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                owner_q, owner_d;  // 1 = data requester
  logic                cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
  logic [DATA_W-1:0]   if_data_q, if_data_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                grant_dm;
  logic                capture;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_owner_q, last_owner_d;
  // Under contention the requester that was not served last wins.
  assign grant_dm = dm_req_i & (~if_req_i | ~last_owner_q);
`else
  assign grant_dm = dm_req_i;
`endif

  assign capture = ((state_q == StIssue) && (LATENCY == 1)) ||
                   ((state_q == StWait) && (cnt_q == 4'd1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    if_data_d   = if_data_q;
    dm_rdata_d  = dm_rdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_owner_d = last_owner_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (dm_req_i || if_req_i) begin
          owner_d     = grant_dm;
          cmd_we_d    = grant_dm & dm_we_i;
          cmd_addr_d  = grant_dm ? dm_addr_i : if_addr_i;
          cmd_wdata_d = grant_dm ? dm_wdata_i : '0;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = 4'(LATENCY - 1);
        state_d = (LATENCY == 1) ? StDone : StWait;
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StDone;
      end
      StDone: begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_owner_d = owner_q;
`endif
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (capture) begin
      if (owner_q) begin
        if (!cmd_we_q) dm_rdata_d = mem_rdata_i;
      end else begin
        if_data_d = mem_rdata_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      if_data_q   <= '0;
      dm_rdata_q  <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_owner_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      if_data_q   <= if_data_d;
      dm_rdata_q  <= dm_rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  assign mem_req_o   = (state_q == StIssue);
  assign mem_we_o    = cmd_we_q;
  assign mem_addr_o  = cmd_addr_q;
  assign mem_wdata_o = cmd_wdata_q;
  assign if_ack_o    = (state_q == StDone) & ~owner_q;
  assign dm_ack_o    = (state_q == StDone) & owner_q;
  assign if_data_o   = if_data_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign stall_o     = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: LATENCY=2 instance plus a LATENCY=1 instance.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_ack, dm_req, dm_we, dm_ack, mem_req, mem_we, stall;
  logic [31:0] if_addr, if_data, dm_addr, dm_wdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        l1_if_req, l1_if_ack, l1_dm_req, l1_dm_we, l1_dm_ack, l1_mem_req, l1_mem_we;
  logic        l1_stall;
  logic [31:0] l1_if_addr, l1_if_data, l1_dm_addr, l1_dm_wdata, l1_dm_rdata;
  logic [31:0] l1_mem_addr, l1_mem_wdata, l1_mem_rdata;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_data_o(if_data),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_ack_o(dm_ack), .dm_rdata_o(dm_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .stall_o(stall)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(l1_if_req), .if_addr_i(l1_if_addr), .if_ack_o(l1_if_ack),
    .if_data_o(l1_if_data),
    .dm_req_i(l1_dm_req), .dm_we_i(l1_dm_we), .dm_addr_i(l1_dm_addr),
    .dm_wdata_i(l1_dm_wdata), .dm_ack_o(l1_dm_ack), .dm_rdata_o(l1_dm_rdata),
    .mem_req_o(l1_mem_req), .mem_we_o(l1_mem_we), .mem_addr_o(l1_mem_addr),
    .mem_wdata_o(l1_mem_wdata), .mem_rdata_i(l1_mem_rdata), .stall_o(l1_stall)
  );

  function automatic logic [31:0] init_val(input logic [31:0] a);
    case (a)
      32'h10:  return 32'h00A00093;
      32'h04:  return 32'h11111111;
      32'h08:  return 32'h22222222;
      32'h30:  return 32'h00000055;
      default: return 32'h0;
    endcase
  endfunction

  // Memory model: data valid only in the cycle LATENCY-1 after the command, garbage otherwise.
  bit          wr_valid [64];
  logic [31:0] mem_arr  [64];
  always @(posedge clk) begin
    if (mem_req && mem_we) begin
      mem_arr[mem_addr[7:2]]  <= mem_wdata;
      wr_valid[mem_addr[7:2]] <= 1'b1;
    end
    if (mem_req && !mem_we)
      mem_rdata <= wr_valid[mem_addr[7:2]] ? mem_arr[mem_addr[7:2]] : init_val(mem_addr);
    else
      mem_rdata <= 32'hBAD0BAD0;
  end
  assign l1_mem_rdata = l1_mem_req ? init_val(l1_mem_addr) : 32'hBAD0BAD0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        is_dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_if;
    logic [31:0] exp_dm;
  } vec_t;

  vec_t vecs [5];
  logic order [4];
  int   n_acks;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,        32'h00A00093, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h08, 32'h0,        32'h00A00093, 32'h22222222};
    vecs[2] = '{1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 32'h00A00093, 32'h22222222};
    vecs[3] = '{1'b1, 1'b0, 32'h20, 32'h0,        32'h00A00093, 32'hDEADBEEF};
    vecs[4] = '{1'b0, 1'b0, 32'h04, 32'h0,        32'h11111111, 32'hDEADBEEF};

    rst = 1'b1;
    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    l1_if_req = 0; l1_if_addr = 0; l1_dm_req = 0; l1_dm_we = 0; l1_dm_addr = 0;
    l1_dm_wdata = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst if_data", if_data, 32'h0);
    chk("rst dm_rdata", dm_rdata, 32'h0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    chk_bit("rst mem_req", mem_req, 1'b0);
    chk_bit("rst mem_we", mem_we, 1'b0);
    chk_bit("rst if_ack", if_ack, 1'b0);
    chk_bit("rst dm_ack", dm_ack, 1'b0);
    chk_bit("rst stall", stall, 1'b0);
    next_cycle();

    // Single-requester transactions, back to back.
    for (int v = 0; v < 5; v++) begin
      if_req = !vecs[v].is_dm; if_addr = vecs[v].addr;
      dm_req = vecs[v].is_dm;  dm_addr = vecs[v].addr;
      dm_we = vecs[v].we;      dm_wdata = vecs[v].wdata;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        chk_bit($sformatf("v%0d c%0d mem_req", v, c), mem_req, c == 1);
        chk_bit($sformatf("v%0d c%0d stall", v, c), stall, c != 3);
        chk_bit($sformatf("v%0d c%0d if_ack", v, c), if_ack, (c == 3) && !vecs[v].is_dm);
        chk_bit($sformatf("v%0d c%0d dm_ack", v, c), dm_ack, (c == 3) && vecs[v].is_dm);
        if (c == 1) begin
          chk($sformatf("v%0d mem_addr", v), mem_addr, vecs[v].addr);
          chk_bit($sformatf("v%0d mem_we", v), mem_we, vecs[v].we);
          if (vecs[v].we) chk($sformatf("v%0d mem_wdata", v), mem_wdata, vecs[v].wdata);
        end
        if (c == 3) begin
          chk($sformatf("v%0d if_data", v), if_data, vecs[v].exp_if);
          chk($sformatf("v%0d dm_rdata", v), dm_rdata, vecs[v].exp_dm);
        end
        next_cycle();
      end
      if_req = 0; dm_req = 0; dm_we = 0;
    end

    // Simultaneous fetch 0x4 and load 0x8: load first, then fetch.
    if_req = 1; if_addr = 32'h4; dm_req = 1; dm_we = 0; dm_addr = 32'h8;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk_bit($sformatf("sim c%0d mem_req", c), mem_req, (c == 1) || (c == 5));
      chk_bit($sformatf("sim c%0d dm_ack", c), dm_ack, c == 3);
      chk_bit($sformatf("sim c%0d if_ack", c), if_ack, c == 7);
      chk_bit($sformatf("sim c%0d stall", c), stall, c != 7);
      if (c == 1) chk("sim load addr", mem_addr, 32'h8);
      if (c == 3) chk("sim dm_rdata", dm_rdata, 32'h22222222);
      if (c == 5) chk("sim fetch addr", mem_addr, 32'h4);
      if (c == 7) chk("sim if_data", if_data, 32'h11111111);
      next_cycle();
      if (c == 3) dm_req = 0;
    end
    if_req = 0;

    // Both held for four grants.
    n_acks = 0;
    if_req = 1; dm_req = 1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk_bit($sformatf("hold c%0d dual ack", c), if_ack & dm_ack, 1'b0);
      if (if_ack || dm_ack) begin
        if (n_acks < 4) order[n_acks] = dm_ack;
        n_acks++;
      end
      next_cycle();
    end
    if_req = 0; dm_req = 0;
    chk("hold ack count", n_acks, 4);
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      chk_bit($sformatf("hold grant%0d is_dm", i), order[i], (i % 2) == 0);
`else
      chk_bit($sformatf("hold grant%0d is_dm", i), order[i], 1'b1);
`endif
    end

    // Reset during WAIT of a load; the held request restarts afterwards.
    dm_req = 1; dm_we = 0; dm_addr = 32'h8;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    chk_bit("rstw issue mem_req", mem_req, 1'b1);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk_bit("rstw wait dm_ack", dm_ack, 1'b0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rstw if_data", if_data, 32'h0);
    chk("rstw dm_rdata", dm_rdata, 32'h0);
    chk("rstw mem_addr", mem_addr, 32'h0);
    chk_bit("rstw mem_req", mem_req, 1'b0);
    chk_bit("rstw dm_ack", dm_ack, 1'b0);
    chk_bit("rstw stall", stall, 1'b1);
    for (int c = 1; c < 4; c++) begin
      next_cycle();
      @(negedge clk);
      chk_bit($sformatf("rstw c%0d mem_req", c), mem_req, c == 1);
      chk_bit($sformatf("rstw c%0d dm_ack", c), dm_ack, c == 3);
      if (c == 3) chk("rstw dm_rdata reload", dm_rdata, 32'h22222222);
    end
    next_cycle();
    dm_req = 0;

    // LATENCY=1 instance: load 0x30.
    l1_dm_req = 1; l1_dm_we = 0; l1_dm_addr = 32'h30;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_bit($sformatf("l1 c%0d mem_req", c), l1_mem_req, c == 1);
      chk_bit($sformatf("l1 c%0d dm_ack", c), l1_dm_ack, c == 2);
      chk_bit($sformatf("l1 c%0d stall", c), l1_stall, c != 2);
      if (c == 1) chk("l1 mem_addr", l1_mem_addr, 32'h30);
      if (c == 2) chk("l1 dm_rdata", l1_dm_rdata, 32'h55);
      next_cycle();
    end
    l1_dm_req = 0;

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
